// File: rtl/param_vending_machine_if.sv
// Coin / dispense / change bundle for param_vending_machine.
// master drives the coin strobes and ChangeAck; slave is the vending core.
interface param_vending_machine_if #(
    parameter int CREDIT_W = 8
);
    logic                N;
    logic                D;
    logic                Q;
    logic                Cancel;
    logic                ChangeAck;
    logic                Candy;
    logic [CREDIT_W-1:0] Number;
    logic                ChangeValid;
    logic [CREDIT_W-1:0] Change;
    logic                CoinReject;

    modport master (
        output N, D, Q, Cancel, ChangeAck,
        input  Candy, Number, ChangeValid, Change, CoinReject
    );

    modport slave (
        input  N, D, Q, Cancel, ChangeAck,
        output Candy, Number, ChangeValid, Change, CoinReject
    );
endinterface

// File: rtl/param_vending_machine.sv
// Parameterised vending machine: accumulates N/D/Q coins, dispenses at PRICE,
// returns change via a valid/ack hold. Optional refund-on-cancel: VEND_CANCEL_EN.
module param_vending_machine #(
    parameter int PRICE    = 25,
    parameter int CREDIT_W = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    param_vending_machine_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    // one extra bit so credit+coin never wraps before the price compare
    localparam int            SW       = CREDIT_W + 1;
    localparam logic [SW-1:0] LP_PRICE = SW'(PRICE);
    localparam logic [SW-1:0] LP_NICK  = SW'(5);
    localparam logic [SW-1:0] LP_DIME  = SW'(10);
    localparam logic [SW-1:0] LP_QUAR  = SW'(25);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W-1:0] r_refund;
    logic [CREDIT_W-1:0] w_refund_nxt;
    logic [CREDIT_W-1:0] r_change;
    logic [CREDIT_W-1:0] w_change_nxt;
    logic                r_candy;
    logic                w_candy_nxt;
    logic                r_reject;
    logic                w_reject_nxt;
    logic                r_cv;
    logic                w_cv_nxt;

    logic                w_any;
    logic                w_one;
    logic                w_open;
    logic                w_cancel;
    logic                w_cancel_hit;
    logic [SW-1:0]       w_coin;
    logic [SW-1:0]       w_sum;
    logic [SW-1:0]       w_over;

`ifdef VEND_CANCEL_EN
    assign w_cancel = bus.Cancel;
`else
    // Cancel stays on the port but can never take effect
    assign w_cancel = 1'b0 & bus.Cancel;
`endif

    assign w_any  = bus.N | bus.D | bus.Q;
    // odd parity and not all three high means exactly one strobe
    assign w_one  = (bus.N ^ bus.D ^ bus.Q) & ~(bus.N & bus.D & bus.Q);
    assign w_open = (r_state == S_IDLE) || (r_state == S_COLLECT);

    assign w_cancel_hit = w_cancel && (r_state == S_COLLECT);

    // coin value is only meaningful when w_one is set
    assign w_coin = (bus.N ? LP_NICK : '0)
                  + (bus.D ? LP_DIME : '0)
                  + (bus.Q ? LP_QUAR : '0);
    assign w_sum  = {1'b0, r_credit} + w_coin;
    assign w_over = w_sum - LP_PRICE;

    // state register and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_refund <= '0;
            r_change <= '0;
            r_candy  <= 1'b0;
            r_reject <= 1'b0;
            r_cv     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_refund <= w_refund_nxt;
            r_change <= w_change_nxt;
            r_candy  <= w_candy_nxt;
            r_reject <= w_reject_nxt;
            r_cv     <= w_cv_nxt;
        end
    end

    // next state, credit and pending refund
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_refund_nxt = r_refund;
        unique case (r_state)
            S_IDLE, S_COLLECT: begin
                if (w_cancel_hit) begin
                    w_state_nxt  = S_CHANGE;
                    w_refund_nxt = r_credit;
                    w_credit_nxt = '0;
                end else if (w_one) begin
                    if (w_sum < LP_PRICE) begin
                        w_state_nxt  = S_COLLECT;
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                    end else begin
                        w_state_nxt  = S_VEND;
                        w_credit_nxt = '0;
                        w_refund_nxt = w_over[CREDIT_W-1:0];
                    end
                end
            end
            S_VEND: begin
                if (r_refund != '0) begin
                    w_state_nxt = S_CHANGE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHANGE: begin
                if (bus.ChangeAck) begin
                    w_state_nxt  = S_IDLE;
                    w_refund_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_credit_nxt = '0;
                w_refund_nxt = '0;
            end
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        w_candy_nxt  = (w_state_nxt == S_VEND);
        w_reject_nxt = w_any && !(w_open && w_one && !w_cancel_hit);
        w_cv_nxt     = (w_state_nxt == S_CHANGE);
        w_change_nxt = w_cv_nxt ? w_refund_nxt : '0;
    end

    assign bus.Candy       = r_candy;
    assign bus.Number      = r_credit;
    assign bus.ChangeValid = r_cv;
    assign bus.Change      = r_change;
    assign bus.CoinReject  = r_reject;

endmodule

// File: tb/tb_param_vending_machine.sv
// Directed bench for param_vending_machine: PRICE=25 core plus a PRICE=40
// core for the cancel path; expectations follow VEND_CANCEL_EN.
module tb_param_vending_machine;

    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    param_vending_machine_if #(.CREDIT_W(8)) a_if ();
    param_vending_machine_if #(.CREDIT_W(8)) b_if ();

    param_vending_machine #(.PRICE(25), .CREDIT_W(8)) u_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (a_if.slave)
    );

    param_vending_machine #(.PRICE(40), .CREDIT_W(8)) u_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input logic n, input logic d, input logic q,
                         input logic c, input logic k);
        a_if.N = n; a_if.D = d; a_if.Q = q;
        a_if.Cancel = c; a_if.ChangeAck = k;
    endtask

    task automatic drv_b(input logic n, input logic d, input logic q,
                         input logic c, input logic k);
        b_if.N = n; b_if.D = d; b_if.Q = q;
        b_if.Cancel = c; b_if.ChangeAck = k;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
        tick();
        chk("rst_number", a_if.Number, 0);
        chk("rst_candy", a_if.Candy, 0);
        chk("rst_cv", a_if.ChangeValid, 0);
        chk("rst_change", a_if.Change, 0);
        chk("rst_reject", a_if.CoinReject, 0);
        chk("rst_b_number", b_if.Number, 0);
        Reset = 1'b0;

        // single quarter vends exactly
        drv_a(0, 0, 1, 0, 0); tick();
        chk("q_candy", a_if.Candy, 1);
        chk("q_number", a_if.Number, 0);
        chk("q_cv", a_if.ChangeValid, 0);
        drv_a(0, 0, 0, 0, 0); tick();
        chk("q_candy_off", a_if.Candy, 0);
        chk("q_cv_off", a_if.ChangeValid, 0);
        tick();
        chk("q_cv_idle", a_if.ChangeValid, 0);

        // N, D, D
        drv_a(1, 0, 0, 0, 0); tick();
        chk("ndd_5", a_if.Number, 5);
        drv_a(0, 1, 0, 0, 0); tick();
        chk("ndd_15", a_if.Number, 15);
        tick();
        chk("ndd_candy", a_if.Candy, 1);
        chk("ndd_number", a_if.Number, 0);
        drv_a(0, 0, 0, 0, 0); tick();
        chk("ndd_candy_off", a_if.Candy, 0);
        chk("ndd_cv", a_if.ChangeValid, 0);

        // D, D, Q -> change 20 held until ack, Q rejected meanwhile
        drv_a(0, 1, 0, 0, 0); tick();
        chk("ddq_10", a_if.Number, 10);
        tick();
        chk("ddq_20", a_if.Number, 20);
        drv_a(0, 0, 1, 0, 0); tick();
        chk("ddq_candy", a_if.Candy, 1);
        chk("ddq_number", a_if.Number, 0);
        chk("ddq_cv_vend", a_if.ChangeValid, 0);
        drv_a(0, 0, 0, 0, 0); tick();
        chk("chg1_cv", a_if.ChangeValid, 1);
        chk("chg1_val", a_if.Change, 20);
        chk("chg1_candy", a_if.Candy, 0);
        drv_a(0, 0, 1, 0, 0); tick();
        chk("chg2_reject", a_if.CoinReject, 1);
        chk("chg2_val", a_if.Change, 20);
        chk("chg2_number", a_if.Number, 0);
        drv_a(0, 0, 0, 0, 0); tick();
        chk("chg3_reject", a_if.CoinReject, 0);
        chk("chg3_cv", a_if.ChangeValid, 1);
        chk("chg3_val", a_if.Change, 20);
        drv_a(0, 0, 0, 0, 1); tick();
        chk("ack_cv", a_if.ChangeValid, 0);
        chk("ack_val", a_if.Change, 0);

        // ack outside CHANGE is ignored; double strobe rejected
        drv_a(0, 1, 0, 0, 1); tick();
        chk("dbl_pre", a_if.Number, 10);
        drv_a(1, 1, 0, 0, 0); tick();
        chk("dbl_reject", a_if.CoinReject, 1);
        chk("dbl_number", a_if.Number, 10);
        drv_a(0, 0, 0, 0, 0); tick();
        chk("dbl_reject_off", a_if.CoinReject, 0);
        chk("dbl_hold", a_if.Number, 10);

        // reset in the middle of CHANGE discards the refund
        drv_a(0, 1, 0, 0, 0); tick();
        chk("rc_20", a_if.Number, 20);
        drv_a(0, 0, 1, 0, 0); tick();
        chk("rc_candy", a_if.Candy, 1);
        drv_a(0, 0, 0, 0, 0); tick();
        chk("rc_cv", a_if.ChangeValid, 1);
        chk("rc_val", a_if.Change, 20);
        Reset = 1'b1;
        drv_a(0, 0, 1, 0, 1); tick();
        chk("rc_rst_cv", a_if.ChangeValid, 0);
        chk("rc_rst_val", a_if.Change, 0);
        chk("rc_rst_candy", a_if.Candy, 0);
        chk("rc_rst_reject", a_if.CoinReject, 0);
        chk("rc_rst_number", a_if.Number, 0);
        Reset = 1'b0;
        drv_a(0, 0, 1, 0, 0); tick();
        chk("post_candy", a_if.Candy, 1);
        drv_a(1, 0, 0, 0, 0); tick();
        chk("vend_reject", a_if.CoinReject, 1);
        chk("vend_candy_off", a_if.Candy, 0);
        chk("vend_cv", a_if.ChangeValid, 0);
        chk("vend_number", a_if.Number, 0);
        drv_a(0, 0, 0, 0, 0); tick();
        chk("vend_idle_num", a_if.Number, 0);

        // PRICE=40: D then Cancel
        drv_b(0, 1, 0, 0, 0); tick();
        chk("b_d10", b_if.Number, 10);
        drv_b(0, 0, 0, 1, 0); tick();
`ifdef VEND_CANCEL_EN
        chk("b_can_number", b_if.Number, 0);
        chk("b_can_cv", b_if.ChangeValid, 1);
        chk("b_can_val", b_if.Change, 10);
        chk("b_can_candy", b_if.Candy, 0);
        drv_b(0, 0, 0, 0, 0); tick();
        chk("b_hold_cv", b_if.ChangeValid, 1);
        chk("b_hold_val", b_if.Change, 10);
        chk("b_hold_candy", b_if.Candy, 0);
        drv_b(0, 0, 0, 0, 1); tick();
        chk("b_ack_cv", b_if.ChangeValid, 0);
        chk("b_ack_number", b_if.Number, 0);
        drv_b(0, 1, 0, 0, 0); tick();
        chk("b_d10b", b_if.Number, 10);
        drv_b(1, 0, 0, 1, 0); tick();
        chk("b_cn_reject", b_if.CoinReject, 1);
        chk("b_cn_number", b_if.Number, 0);
        chk("b_cn_val", b_if.Change, 10);
        drv_b(0, 0, 0, 0, 1); tick();
        chk("b_cn_ack", b_if.ChangeValid, 0);
`else
        chk("b_can_number", b_if.Number, 10);
        chk("b_can_cv", b_if.ChangeValid, 0);
        drv_b(0, 0, 0, 0, 0); tick();
        chk("b_hold_number", b_if.Number, 10);
        chk("b_hold_cv", b_if.ChangeValid, 0);
        chk("b_hold_candy", b_if.Candy, 0);
        drv_b(1, 0, 0, 1, 0); tick();
        chk("b_cn_number", b_if.Number, 15);
        chk("b_cn_reject", b_if.CoinReject, 0);
        chk("b_cn_cv", b_if.ChangeValid, 0);
`endif
        drv_b(0, 0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
